alu_operations_five: RTL and testbench

Registered two-stage integer ALU for the execute (EX) stage of the five-stage RISC-V pipeline. It captures the ID/EX operand pair and a 6-bit operation code when `load` is asserted. One clock later it presents the registered 32-bit result of add, subtract, AND, OR, signed set-less-than or low-word multiply. The result holds until a new operation completes.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_core.sv | 28 ++
 rtl/alu_operations_five.sv | 49 ++++
 tb/tb_alu_operations_five.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the EX-stage ALU.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 6;

  localparam logic [OPW-1:0] ALU_ADD = 6'b000000;
  localparam logic [OPW-1:0] ALU_SUB = 6'b000001;
  localparam logic [OPW-1:0] ALU_AND = 6'b000010;
  localparam logic [OPW-1:0] ALU_OR  = 6'b000011;
  localparam logic [OPW-1:0] ALU_SLT = 6'b000100;
  localparam logic [OPW-1:0] ALU_MUL = 6'b000101;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU function f(a, b, op); unknown opcodes produce zero.
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OPW-1:0]  op,
  output logic [XLEN-1:0] result
);

  // The low word of a product is identical for signed and unsigned operands.
  logic [XLEN-1:0] mul_lo;
  assign mul_lo = a * b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_MUL: result = mul_lo;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_operations_five.sv
// Two-stage registered ALU: stage 1 captures operands on load, stage 2
// registers the result one edge later and holds it until the next capture.
module alu_operations_five
  import alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic signed [XLEN-1:0]  ID_EX_A,
  input  logic signed [XLEN-1:0]  ID_EX_B,
  input  logic [OPW-1:0]          opcode,
  output logic signed [XLEN-1:0]  ALU_result
);

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [OPW-1:0]  op_q;
  logic            valid_q;
  logic [XLEN-1:0] core_result;

  alu_core u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_result)
  );

  // valid_q marks a fresh capture, so each capture writes the output once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      valid_q    <= 1'b0;
      ALU_result <= '0;
    end else begin
      valid_q <= load;
      if (load) begin
        a_q  <= ID_EX_A;
        b_q  <= ID_EX_B;
        op_q <= opcode;
      end
      if (valid_q) begin
        ALU_result <= core_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_operations_five.sv
// Directed bench for alu_operations_five: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is due.
module tb_alu_operations_five;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] id_ex_a;
  logic [31:0] id_ex_b;
  logic [5:0]  opcode;
  logic [31:0] alu_result;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] last_exp;
  logic        due1;
  logic        due2;
  int          errors;
  int          checks;

  alu_operations_five dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .ID_EX_A    (id_ex_a),
    .ID_EX_B    (id_ex_b),
    .opcode     (opcode),
    .ALU_result (alu_result)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op, input logic [31:0] exp);
    @(negedge clk);
    id_ex_a = a;
    id_ex_b = b;
    opcode  = op;
    load    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load    = 1'b0;
      id_ex_a = $urandom();
      id_ex_b = $urandom();
      opcode  = 6'($urandom_range(0, 63));
    end
  endtask

  // Bench-side timing: a result is due one edge after the capturing edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      due1 <= 1'b0;
      due2 <= 1'b0;
    end else begin
      due1 <= load;
      due2 <= due1;
    end
  end

  // scoreboard monitor
  initial begin
    string nm;
    last_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        name_q.delete();
        last_exp = '0;
        check("reset_zero", alu_result, 32'd0);
      end else if (due2) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL no_expect: result 0x%08h appeared with empty queue", alu_result);
        end else begin
          last_exp = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, alu_result, last_exp);
        end
      end else begin
        check("hold", alu_result, last_exp);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    id_ex_a = '0;
    id_ex_b = '0;
    opcode  = '0;
    errors  = 0;
    checks  = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    issue("add_10_5", 32'd10, 32'd5, 6'b000000, 32'd15);
    idle(4);
    issue("sub_20_8", 32'd20, 32'd8, 6'b000001, 32'd12);
    idle(3);
    issue("sub_5_10", 32'd5, 32'd10, 6'b000001, 32'hFFFF_FFFB);
    idle(3);
    issue("and_mask", 32'hFF00_FF00, 32'h0F0F_0F0F, 6'b000010, 32'h0F00_0F00);
    idle(2);
    issue("or_mask", 32'hFF00_FF00, 32'h0F0F_0F0F, 6'b000011, 32'hFF0F_FF0F);
    idle(2);

    // back-to-back captures, one result per cycle
    issue("slt_15_20", 32'd15, 32'd20, 6'b000100, 32'd1);
    issue("slt_25_20", 32'd25, 32'd20, 6'b000100, 32'd0);
    issue("slt_neg1_1", 32'hFFFF_FFFF, 32'd1, 6'b000100, 32'd1);
    issue("slt_1_neg1", 32'd1, 32'hFFFF_FFFF, 6'b000100, 32'd0);
    issue("mul_6_7", 32'd6, 32'd7, 6'b000101, 32'd42);
    issue("mul_wrap", 32'd65536, 32'd65536, 6'b000101, 32'd0);
    issue("mul_neg3_7", 32'hFFFF_FFFD, 32'd7, 6'b000101, 32'hFFFF_FFEB);
    issue("add_wrap", 32'hFFFF_FFFF, 32'd2, 6'b000000, 32'd1);
    issue("bad_op_3f", 32'hAAAA_AAAA, 32'h1234_5678, 6'b111111, 32'd0);
    issue("bad_op_06", 32'd9, 32'd3, 6'b000110, 32'd0);
    idle(4);

    // reset while an operation is pending
    issue("mul_pre", 32'd6, 32'd7, 6'b000101, 32'd42);
    idle(3);
    issue("discarded", 32'd1, 32'd2, 6'b000000, 32'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    check("reset_async", alu_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    issue("add_after_rst", 32'd100, 32'd23, 6'b000000, 32'd123);
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
